// File: rtl/ula_seq_nbyte_if.sv
// rtl/ula_seq_nbyte_if.sv - request, ALU byte bus and response signals of the byte-serial ALU sequencer
interface ula_seq_nbyte_if #(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_s;
  logic         req_m;
  logic         req_cin;

  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cin;
  logic [7:0]   alu_f;
  logic         alu_cout;
  logic         alu_aeqb;
  logic         alu_ovf;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_cout;
  logic         rsp_aeqb;
  logic         rsp_ovf;

  // slave: the sequencer; master: requester plus the external ALU
  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_cin,
    output req_ready,
    output alu_a, alu_b, alu_s, alu_m, alu_cin,
    input  alu_f, alu_cout, alu_aeqb, alu_ovf,
    output rsp_valid, rsp_f, rsp_cout, rsp_aeqb, rsp_ovf,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_cin,
    input  req_ready,
    input  alu_a, alu_b, alu_s, alu_m, alu_cin,
    output alu_f, alu_cout, alu_aeqb, alu_ovf,
    input  rsp_valid, rsp_f, rsp_cout, rsp_aeqb, rsp_ovf,
    output rsp_ready
  );
endinterface

// File: rtl/ula_seq_nbyte.sv
// rtl/ula_seq_nbyte.sv - drives one 8-bit ALU byte-serially, LSB first, for NBYTES-wide ops
// Optional macro ULA_SEQ_B2B_EN lets a new request be accepted on the edge that consumes a response.
module ula_seq_nbyte #(
  parameter int NBYTES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_seq_nbyte_if.slave bus
);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] f_q;
  logic [3:0]             s_q;
  logic                   m_q;
  logic                   cin_q;
  logic                   carry_q;
  logic                   aeqb_q;
  logic                   cout_q;
  logic                   ovf_q;

  logic                   ready;
  logic                   accept;
  logic                   exec;

`ifdef ULA_SEQ_B2B_EN
  assign ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
`else
  assign ready = (state == IDLE);
`endif

  assign accept        = bus.req_valid && ready;
  assign exec          = (state == EXEC);
  assign bus.req_ready = ready;

  // ALU drive comes only from registers, so no request input reaches the ALU in the same cycle
  assign bus.alu_a   = exec ? a_q[cnt] : 8'h00;
  assign bus.alu_b   = exec ? b_q[cnt] : 8'h00;
  assign bus.alu_s   = exec ? s_q : 4'h0;
  assign bus.alu_m   = exec && m_q;
  assign bus.alu_cin = exec && ((cnt == '0) ? cin_q : carry_q);

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_f     = f_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_aeqb  = aeqb_q;
  assign bus.rsp_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      aeqb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            s_q   <= bus.req_s;
            m_q   <= bus.req_m;
            cin_q <= bus.req_cin;
            cnt   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          f_q[cnt] <= bus.alu_f;
          carry_q  <= bus.alu_cout;
          aeqb_q   <= (cnt == '0) ? bus.alu_aeqb : (aeqb_q && bus.alu_aeqb);
          if (cnt == LAST) begin
            // logic mode still clocks the carry chain but never reports carry or overflow
            cout_q <= !m_q && bus.alu_cout;
            ovf_q  <= !m_q && bus.alu_ovf;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // accept can only be true here in back-to-back mode, where rsp_ready is also high
          if (accept) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            s_q   <= bus.req_s;
            m_q   <= bus.req_m;
            cin_q <= bus.req_cin;
            cnt   <= '0;
            state <= EXEC;
          end else if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq_nbyte.sv
// tb/tb_ula_seq_nbyte.sv - self-checking bench for ula_seq_nbyte with NBYTES=2 and NBYTES=4 instances
module tb_ula_seq_nbyte;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_seq_nbyte_if #(.NBYTES(2)) b2 ();
  ula_seq_nbyte_if #(.NBYTES(4)) b4 ();

  ula_seq_nbyte #(.NBYTES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  ula_seq_nbyte #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // external 8-bit ALU: {ovf, aeqb, cout, f}
  function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
    logic [8:0] sum;
    logic [7:0] f;
    logic       co;
    logic       ov;
    sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    f = a; co = 1'b0; ov = 1'b0;
    if (!m && s == 4'b1001) begin
      f  = sum[7:0];
      co = sum[8];
      ov = (a[7] == b[7]) && (f[7] != a[7]);
    end else if (m && s == 4'b0110) begin
      f = a ^ b;
    end
    return {ov, (a == b), co, f};
  endfunction

  assign {b2.alu_ovf, b2.alu_aeqb, b2.alu_cout, b2.alu_f} =
      alu_model(b2.alu_a, b2.alu_b, b2.alu_s, b2.alu_m, b2.alu_cin);
  assign {b4.alu_ovf, b4.alu_aeqb, b4.alu_cout, b4.alu_f} =
      alu_model(b4.alu_a, b4.alu_b, b4.alu_s, b4.alu_m, b4.alu_cin);

  // whole-word reference: {ovf, aeqb, cout, f[31:0]}
  function automatic logic [34:0] ref_op(input int nb, input logic [31:0] a, input logic [31:0] b,
                                         input logic m, input logic cin);
    int          w;
    logic [63:0] mask;
    logic [63:0] sum;
    logic [31:0] f;
    logic        co;
    logic        ov;
    logic        eq;
    w    = 8 * nb;
    mask = (64'd1 << w) - 64'd1;
    eq   = ((a ^ b) & mask[31:0]) == 32'd0;
    if (m) begin
      f = (a ^ b) & mask[31:0]; co = 1'b0; ov = 1'b0;
    end else begin
      sum = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
      f   = sum[31:0] & mask[31:0];
      co  = sum[w];
      ov  = (a[w-1] == b[w-1]) && (f[w-1] != a[w-1]);
    end
    return {ov, eq, co, f};
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
    int n = 0;
    b2.req_a = a; b2.req_b = b; b2.req_s = s; b2.req_m = m; b2.req_cin = cin;
    b2.req_valid = 1'b1;
    while (!b2.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("start2_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
  endtask

  task automatic wait_rsp2(output int lat);
    int n = 0;
    while (!b2.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    lat = n;
  endtask

  task automatic take2();
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  task automatic op2(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] s, input logic m, input logic cin);
    int          lat;
    logic [34:0] e;
    start2(a, b, s, m, cin);
    wait_rsp2(lat);
    e = ref_op(2, 32'(a), 32'(b), m, cin);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_f"}, b2.rsp_f, e[15:0]);
    chk({tag, "_cout"}, b2.rsp_cout, e[32]);
    chk({tag, "_aeqb"}, b2.rsp_aeqb, e[33]);
    chk({tag, "_ovf"}, b2.rsp_ovf, e[34]);
    take2();
  endtask

  task automatic op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] s, input logic m, input logic cin);
    int          n = 0;
    logic [34:0] e;
    b4.req_a = a; b4.req_b = b; b4.req_s = s; b4.req_m = m; b4.req_cin = cin;
    b4.req_valid = 1'b1;
    while (!b4.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    b4.req_valid = 1'b0;
    n = 0;
    while (!b4.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    e = ref_op(4, a, b, m, cin);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_f"}, b4.rsp_f, e[31:0]);
    chk({tag, "_cout"}, b4.rsp_cout, e[32]);
    chk({tag, "_aeqb"}, b4.rsp_aeqb, e[33]);
    chk({tag, "_ovf"}, b4.rsp_ovf, e[34]);
    b4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b4.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] hold_f;
    logic [15:0] qa[3];
    logic [15:0] qb[3];
    logic [34:0] e;
    int          idx;
    int          got;
    int          cyc;
    int          last_t;
    int          gap;
    logic        acc;
    logic        m;
    logic [15:0] ra;
    logic [15:0] rb;

    b2.req_valid = 0; b2.req_a = 0; b2.req_b = 0; b2.req_s = 0; b2.req_m = 0; b2.req_cin = 0;
    b2.rsp_ready = 0;
    b4.req_valid = 0; b4.req_a = 0; b4.req_b = 0; b4.req_s = 0; b4.req_m = 0; b4.req_cin = 0;
    b4.rsp_ready = 0;

    #1;
    chk("rst_req_ready", b2.req_ready, 1'b1);
    chk("rst_rsp_valid", b2.rsp_valid, 1'b0);
    chk("rst_rsp_f", b2.rsp_f, 16'h0000);
    chk("rst_alu", {b2.alu_a, b2.alu_b, b2.alu_s, b2.alu_m, b2.alu_cin}, 22'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // byte-by-byte drive and carry chaining
    start2(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    chk("t1_b0_a", b2.alu_a, 8'hFF);
    chk("t1_b0_b", b2.alu_b, 8'h01);
    chk("t1_b0_cin", b2.alu_cin, 1'b0);
    chk("t1_busy", b2.req_ready, 1'b0);
    @(posedge clk); #1;
    chk("t1_b1_a", b2.alu_a, 8'h12);
    chk("t1_b1_b", b2.alu_b, 8'h00);
    chk("t1_b1_cin", b2.alu_cin, 1'b1);
    chk("t1_b1_nrsp", b2.rsp_valid, 1'b0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", b2.rsp_valid, 1'b1);
    chk("t1_rsp_f", b2.rsp_f, 16'h1300);
    chk("t1_cout", b2.rsp_cout, 1'b0);
    chk("t1_ovf", b2.rsp_ovf, 1'b0);
    chk("t1_alu_idle", {b2.alu_a, b2.alu_cin}, 9'h0);
    take2();

    op2("t2_ovf", 16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    op2("t2_carry", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    op2("t3_xor_eq", 16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b0);
    op2("t3_xor_ne", 16'hA5A5, 16'hA5A4, 4'b0110, 1'b1, 1'b1);

    // response backpressure with a competing request
    start2(16'h3456, 16'h1111, 4'b1001, 1'b0, 1'b1);
    wait_rsp2(idx);
    hold_f = b2.rsp_f;
    chk("t4_f", hold_f, 16'h4568);
    b2.req_a = 16'h0F0F; b2.req_b = 16'h0101; b2.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", b2.rsp_valid, 1'b1);
      chk("t4_hold_f", b2.rsp_f, hold_f);
      chk("t4_not_ready", b2.req_ready, 1'b0);
    end
    b2.req_valid = 1'b0;
    take2();
    chk("t4_idle_valid", b2.rsp_valid, 1'b0);
    chk("t4_idle_ready", b2.req_ready, 1'b1);

    // asynchronous reset in the middle of EXEC
    start2(16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t5_cnt1", b2.alu_a, 8'hAB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_alu", {b2.alu_a, b2.alu_b, b2.alu_s, b2.alu_m, b2.alu_cin}, 22'h0);
    chk("t5_rst_rsp", {b2.rsp_valid, b2.rsp_f, b2.rsp_cout, b2.rsp_aeqb, b2.rsp_ovf}, 20'h0);
    chk("t5_rst_ready", b2.req_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op2("t5_after", 16'h0102, 16'h0304, 4'b1001, 1'b0, 1'b0);

    // streaming with requests and response ready held high
`ifdef ULA_SEQ_B2B_EN
    gap = 3;
`else
    gap = 4;
`endif
    for (int i = 0; i < 3; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
    end
    idx = 0; got = 0; cyc = 0; last_t = 0;
    b2.req_a = qa[0]; b2.req_b = qb[0]; b2.req_s = 4'b1001; b2.req_m = 1'b0; b2.req_cin = 1'b0;
    b2.req_valid = 1'b1;
    b2.rsp_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      acc = b2.req_valid && b2.req_ready;
      if (b2.rsp_valid) begin
        e = ref_op(2, 32'(qa[got]), 32'(qb[got]), 1'b0, 1'b0);
        chk("t6_f", b2.rsp_f, e[15:0]);
        chk("t6_cout", b2.rsp_cout, e[32]);
        if (got > 0) chk("t6_gap", cyc - last_t, gap);
        last_t = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          b2.req_a = qa[idx]; b2.req_b = qb[idx];
        end else begin
          b2.req_valid = 1'b0;
        end
      end
    end
    chk("t6_count", got, 3);
    b2.req_valid = 1'b0;
    b2.rsp_ready = 1'b0;
    for (int i = 0; i < 4 && b2.rsp_valid; i++) take2();

    // randomized ops against the word-level model
    for (int i = 0; i < 16; i++) begin
      m  = 1'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      op2("rnd2", ra, rb, m ? 4'b0110 : 4'b1001, m, 1'($urandom));
    end

    op4("n4_carry", 32'h00FF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom);
      op4("rnd4", $urandom, $urandom, m ? 4'b0110 : 4'b1001, m, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ula_seq_nbyte.md
Name: ula_seq_nbyte

Overview:
Byte-serial sequencer that executes NBYTES-wide ALU operations on one external ula_8_bits instance. It is the initiator/driver side of the ALU's operand/result interface. It accepts a wide request over a valid/ready handshake and drives the ALU one byte per cycle, LSB first, chaining carry between bytes through a register. It then returns the assembled result and flags over a valid/ready response channel.

Parameters:
NBYTES, 2, operand width in bytes; legal 1..4; W = 8*NBYTES.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready at clk edge
req_a  in  W  operand A
req_b  in  W  operand B
req_s  in  4  ALU function select
req_m  in  1  mode (1 = logic, 0 = arithmetic)
req_cin  in  1  carry-in to byte 0, ALU native polarity
alu_a  out  8  operand byte to ula_8_bits.a
alu_b  out  8  operand byte to ula_8_bits.b
alu_s  out  4  to ula_8_bits.s
alu_m  out  1  to ula_8_bits.m
alu_cin  out  1  to ula_8_bits.c_in
alu_f  in  8  from ula_8_bits.f
alu_cout  in  1  from ula_8_bits.c_out
alu_aeqb  in  1  from ula_8_bits.a_eq_b
alu_ovf  in  1  from ula_8_bits.overflow
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at clk edge
rsp_f  out  W  result
rsp_cout  out  1  carry-out of top byte
rsp_aeqb  out  1  AND of per-byte alu_aeqb
rsp_ovf  out  1  overflow of top byte

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, byte counter=0, all operand/result registers=0, req_ready=1, rsp_valid=0, rsp_f/rsp_cout/rsp_aeqb/rsp_ovf=0, all alu_* outputs=0.
- FSM states:
  - IDLE: req_ready=1. On accept, register a/b/s/m/cin, set cnt=0, and go to EXEC.
  - EXEC: req_ready=0.
    - alu_a=a_q[8*cnt+:8], alu_b=b_q[8*cnt+:8], alu_s=s_q, alu_m=m_q.
    - alu_cin = cin_q when cnt=0, else carry_q.
    - These outputs are combinational from registers only; there is no combinational req→alu path.
    - Each edge captures alu_f into f_q[8*cnt+:8] and alu_cout into carry_q. aeqb_q is set to alu_aeqb at cnt=0 and to aeqb_q & alu_aeqb otherwise.
    - At cnt=NBYTES-1: capture alu_ovf, go to RESP, and set rsp_valid=1. Otherwise cnt++.
  - RESP: rsp_valid=1 and rsp_* are held stable. On rsp_ready, go to IDLE and clear rsp_valid.
- Outside EXEC, all alu_* outputs are 0.
- Latency: accept edge at T0. Byte k is driven during cycle T0+1+k. rsp_valid is high from T0+NBYTES+1. Throughput is one op per NBYTES+2 cycles minimum.
- Mode m=1:
  - The carry chain is still registered but forced: rsp_cout=0 and rsp_ovf=0.
  - alu_cin is still driven per the rule above.
- Request inputs are ignored outside the accept cycle. Changing req_* mid-op has no effect.
- req_valid while busy is not accepted. The requester holds it, per the handshake.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-EXEC or mid-RESP discards the op immediately. The first op after reset completes normally.
- NBYTES=1: EXEC lasts one cycle; rsp_aeqb=alu_aeqb.

Optional Feature:
Macro ULA_SEQ_B2B_EN.
- Defined: req_ready = IDLE | (RESP & rsp_ready).
  - Accept in RESP registers the new op and goes directly to EXEC with cnt=0.
  - Results for the old op are consumed on that same edge.
  - Throughput is one op per NBYTES+1 cycles.
- Undefined: req_ready=1 only in IDLE.

Test Plan:
Bench ALU model: m=0,s=1001 gives f=a+b+cin with cout=carry; m=1,s=0110 gives f=a^b; aeqb=(a==b); ovf is signed-add overflow. NBYTES=2 unless noted.
1. Add 0x12FF+0x0001, cin=0 -> alu sees (FF,01,cin0) then (12,00,cin1); rsp_f=0x1300, cout=0, ovf=0; rsp_valid at T0+3.
2. Add 0x7FFF+0x0001 -> rsp_f=0x8000, ovf=1, cout=0; add 0xFFFF+0x0001 -> rsp_f=0x0000, cout=1, ovf=0.
3. m=1,s=0110, 0xA5A5^0xA5A5 -> rsp_f=0x0000, aeqb=1, cout=0, ovf=0; 0xA5A5^0xA5A4 -> aeqb=0.
4. Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, a second req_valid is not accepted; rsp_ready=1 -> IDLE next cycle.
5. Reset: assert rst_n=0 during EXEC cnt=1 -> all outputs 0 without clk edge; after release, add 0x0102+0x0304 -> rsp_f=0x0406.
6. With ULA_SEQ_B2B_EN: rsp_ready and req_valid held high for 3 adds -> rsp_valid pulses every 3 cycles, results correct in order; NBYTES=4 add 0x00FFFFFF+1 -> 0x01000000.
